// File: rtl/cdb_arbiter.sv
// Common-data-bus arbiter: one-entry holding slot per result producer, rotating-priority
// grant of up to N_LANES held results per cycle onto dense CDB lanes.

package tomasula_types;
  typedef struct packed {
    logic [5:0]  tag;
    logic [31:0] value;
  } cdb_data;
endpackage

// One CDB lane: one-hot select of a held result onto the lane.
module cdb_lane
  import tomasula_types::*;
#(
  parameter int N_REQ = 5
) (
  input  logic    [N_REQ-1:0] sel,
  input  cdb_data [N_REQ-1:0] hold_data,
  output cdb_data             ctl,
  output logic                enable
);
  always_comb begin
    ctl    = '0;
    enable = |sel;
    for (int i = 0; i < N_REQ; i++)
      if (sel[i]) ctl = ctl | hold_data[i];
  end
endmodule

module cdb_arbiter
  import tomasula_types::*;
#(
  parameter int N_REQ   = 5,
  parameter int N_LANES = 2,
  parameter int CNT_W   = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                flush,
  input  logic    [N_REQ-1:0] in_valid,
  input  cdb_data [N_REQ-1:0] in_data,
  output logic    [N_REQ-1:0] in_ready,
  output cdb_data [7:0]       cdb_ctl,
  output logic    [7:0]       cdb_enable,
  output logic    [N_REQ-1:0] grant,
  output logic    [CNT_W-1:0] conflict_cnt
);
  localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  logic    [N_REQ-1:0]            hold_valid;
  cdb_data [N_REQ-1:0]            hold_data;
  logic    [PTR_W-1:0]            rr_ptr, rr_next;
  logic    [N_REQ-1:0]            cand;
  logic    [7:0][N_REQ-1:0]       lane_sel;
  logic                           over;

  // Reset is folded into the candidate mask so nothing is broadcast in a reset cycle.
  assign cand     = (rst && !flush) ? hold_valid : '0;
  assign over     = $countones(cand) > N_LANES;
  assign in_ready = flush ? '0 : (~hold_valid | grant);

  always_comb begin
    logic [PTR_W:0] idx;
    logic [3:0]     k;
    lane_sel = '0;
    grant    = '0;
    rr_next  = rr_ptr;
    k        = '0;
    idx      = '0;
    for (int s = 0; s < N_REQ; s++) begin
      idx = {1'b0, rr_ptr} + (PTR_W+1)'(s);
      if (idx >= (PTR_W+1)'(N_REQ)) idx = idx - (PTR_W+1)'(N_REQ);
      if (cand[idx[PTR_W-1:0]] && k < 4'(N_LANES)) begin
        grant[idx[PTR_W-1:0]]        = 1'b1;
        lane_sel[k[2:0]][idx[PTR_W-1:0]] = 1'b1;
        k       = k + 4'd1;
        rr_next = (idx == (PTR_W+1)'(N_REQ-1)) ? '0 : idx[PTR_W-1:0] + PTR_W'(1);
      end
    end
  end

  generate
    for (genvar l = 0; l < 8; l++) begin : g_lane
      cdb_lane #(.N_REQ(N_REQ)) u_lane (
        .sel       (lane_sel[l]),
        .hold_data (hold_data),
        .ctl       (cdb_ctl[l]),
        .enable    (cdb_enable[l])
      );
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (!rst) begin
      hold_valid   <= '0;
      hold_data    <= '0;
      rr_ptr       <= '0;
      conflict_cnt <= '0;
    end else begin
      if (|grant) rr_ptr <= rr_next;
      if (over && !(&conflict_cnt)) conflict_cnt <= conflict_cnt + CNT_W'(1);
      // Flush beats accept; accept beats grant-clear so a streaming producer never bubbles.
      for (int i = 0; i < N_REQ; i++) begin
        if (flush)                         hold_valid[i] <= 1'b0;
        else if (in_valid[i] && in_ready[i]) begin
          hold_valid[i] <= 1'b1;
          hold_data[i]  <= in_data[i];
        end else if (grant[i])             hold_valid[i] <= 1'b0;
      end
    end
  end
endmodule
